// File: rtl/k210_pkg.sv
// k210_pkg: shared constants and state types
// for the K210 coordinate UART receiver.
package k210_pkg;

  localparam logic [7:0] HDR       = 8'hA5;
  localparam logic [7:0] TAIL      = 8'h5A;
  localparam int         FRAME_LEN = 7;

  typedef enum logic [$clog2(FRAME_LEN)-1:0] {
    P_IDLE,
    P_XH,
    P_XL,
    P_YH,
    P_YL,
    P_SUM,
    P_TAIL
  } prs_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 byte receiver with rx
// synchronizer, byte_valid and framing-error strobes.
module uart_byte_rx
  import k210_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       fe
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_d;
  logic          fall;
  rx_state_t     state;
  rx_state_t     state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic          bv_n;
  logic          fe_n;

  assign fall = rx_d & ~rx_s2;
  assign data = sh;

  // two-flop synchronizer plus edge history, idle-high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // receiver next-state: bit timing and sampling
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    sh_n      = sh;
    bv_n      = 1'b0;
    fe_n      = 1'b0;
    unique case (state)
      R_IDLE: begin
        cnt_n = '0;
        if (fall) state_n = R_START;
      end
      R_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt == CW'(BAUD_DIV - 1)) begin
          cnt_n     = '0;
          sh_n      = {rx_s2, sh[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt == CW'(BAUD_DIV - 1)) begin
          cnt_n   = '0;
          state_n = R_IDLE;
          if (rx_s2) bv_n = 1'b1;
          else       fe_n = 1'b1;
        end
      end
      default: state_n = R_IDLE;
    endcase
  end

  // receiver state and strobe registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sh         <= '0;
      byte_valid <= 1'b0;
      fe         <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      sh         <= sh_n;
      byte_valid <= bv_n;
      fe         <= fe_n;
    end
  end

endmodule

// File: rtl/k210_coor_rx.sv
// k210_coor_rx: K210 coordinate frame parser
// with timeout, error strobe and saturating count.
module k210_coor_rx
  import k210_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [9:0] k210_xpos,
  output logic [9:0] k210_ypos,
  output logic       k210_coor_flag,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]    data;
  logic          byte_valid;
  logic          fe;
  prs_state_t    state;
  prs_state_t    state_n;
  logic [9:0]    x_tmp;
  logic [9:0]    x_n;
  logic [9:0]    y_tmp;
  logic [9:0]    y_n;
  logic [TW-1:0] idle_cnt;
  logic          timeout;
  logic [7:0]    sum_c;
  logic          err_c;
  logic          load_c;
  logic          load_q;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .byte_valid (byte_valid),
    .fe         (fe)
  );

  // XH/YH upper bits are forced zero, so the
  // stored coordinates reproduce the byte sum
  assign sum_c = {6'b0, x_tmp[9:8]} + x_tmp[7:0]
               + {6'b0, y_tmp[9:8]} + y_tmp[7:0];

  assign timeout = (state != P_IDLE) && !byte_valid
                && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  // inter-byte idle counter, only inside a frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (byte_valid || state == P_IDLE) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // parser next-state, one step per byte event
  always_comb begin
    state_n = state;
    x_n     = x_tmp;
    y_n     = y_tmp;
    err_c   = 1'b0;
    load_c  = 1'b0;
    if (state != P_IDLE && (fe || timeout)) begin
      err_c   = 1'b1;
      state_n = P_IDLE;
    end else if (byte_valid) begin
      unique case (state)
        P_IDLE: begin
          if (data == HDR) state_n = P_XH;
        end
        P_XH: begin
          if (data[7:2] != 6'd0) begin
            err_c   = 1'b1;
            state_n = P_IDLE;
          end else begin
            x_n[9:8] = data[1:0];
            state_n  = P_XL;
          end
        end
        P_XL: begin
          x_n[7:0] = data;
          state_n  = P_YH;
        end
        P_YH: begin
          if (data[7:2] != 6'd0) begin
            err_c   = 1'b1;
            state_n = P_IDLE;
          end else begin
            y_n[9:8] = data[1:0];
            state_n  = P_YL;
          end
        end
        P_YL: begin
          y_n[7:0] = data;
          state_n  = P_SUM;
        end
        P_SUM: begin
          if (sum_c != data) begin
            err_c   = 1'b1;
            state_n = P_IDLE;
          end else begin
            state_n = P_TAIL;
          end
        end
        P_TAIL: begin
          state_n = P_IDLE;
          if (data == TAIL) load_c = 1'b1;
          else              err_c  = 1'b1;
        end
        default: state_n = P_IDLE;
      endcase
    end
  end

  // parser state and captured coordinates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= P_IDLE;
      x_tmp  <= '0;
      y_tmp  <= '0;
      load_q <= 1'b0;
    end else begin
      state  <= state_n;
      x_tmp  <= x_n;
      y_tmp  <= y_n;
      load_q <= load_c;
    end
  end

  // outputs load one cycle after the tail byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k210_xpos      <= '0;
      k210_ypos      <= '0;
      k210_coor_flag <= 1'b0;
    end else begin
      k210_coor_flag <= load_q;
      if (load_q) begin
        k210_xpos <= x_tmp;
        k210_ypos <= y_tmp;
      end
    end
  end

  // error strobe and saturating error count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= err_c;
      if (err_c && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_k210_coor_rx.sv
// tb_k210_coor_rx: directed frames over a scaled
// baud rate with immediate-assertion checks.
module tb_k210_coor_rx;

  localparam int CLK_FREQ = 800_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int TMO      = 400;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [9:0] k210_xpos;
  logic [9:0] k210_ypos;
  logic       k210_coor_flag;
  logic       frame_err;
  logic [7:0] err_cnt;

  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   bv_cnt  = 0;
  int   bv_cyc  = 0;
  int   flags   = 0;
  int   lat     = -1;
  int   dbl     = 0;
  int   ferrs   = 0;
  int   bv0     = 0;
  logic prev_fl = 1'b0;

  k210_coor_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx             (rx),
    .k210_xpos      (k210_xpos),
    .k210_ypos      (k210_ypos),
    .k210_coor_flag (k210_coor_flag),
    .frame_err      (frame_err),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  // observe strobes away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (dut.u_rx.byte_valid) begin
      bv_cnt++;
      bv_cyc = cyc;
    end
    if (k210_coor_flag) begin
      flags++;
      lat = cyc - bv_cyc;
      if (prev_fl) dbl++;
    end
    prev_fl = k210_coor_flag;
    if (frame_err) ferrs++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d",
             tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop,
                           input int rst_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10 * BIT; k++) begin
      @(negedge clk);
      rx    = fr[k / BIT];
      rst_n = (k == rst_at) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic send_frame(input logic [55:0] f);
    for (int i = 0; i < 7; i++) begin
      send_byte(f[55 - 8 * i -: 8], 1'b1, -1);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle(4);
    chk("rst_x", k210_xpos, 0);
    chk("rst_y", k210_ypos, 0);
    chk("rst_flag", k210_coor_flag, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_cnt", err_cnt, 0);
    rst_n = 1'b1;
    idle(20);

    send_frame(56'hA5_01_40_00_F0_31_5A);
    idle(10);
    chk("f1_flags", flags, 1);
    chk("f1_x", k210_xpos, 320);
    chk("f1_y", k210_ypos, 240);
    chk("f1_lat", lat, 2);
    chk("f1_ferr", ferrs, 0);

    send_frame(56'hA5_01_40_00_F0_32_5A);
    idle(10);
    chk("sum_ferr", ferrs, 1);
    chk("sum_cnt", err_cnt, 1);
    chk("sum_flags", flags, 1);
    chk("sum_x", k210_xpos, 320);
    chk("sum_y", k210_ypos, 240);

    send_byte(8'h00, 1'b1, -1);
    send_byte(8'hFF, 1'b1, -1);
    send_byte(8'h13, 1'b1, -1);
    send_frame(56'hA5_03_FF_01_DF_E2_5A);
    idle(10);
    chk("f2_flags", flags, 2);
    chk("f2_x", k210_xpos, 1023);
    chk("f2_y", k210_ypos, 479);
    chk("f2_ferr", ferrs, 1);
    chk("f2_lat", lat, 2);

    send_frame(56'hA5_04_FF_01_DF_E2_5A);
    idle(10);
    chk("xh_ferr", ferrs, 2);
    chk("xh_cnt", err_cnt, 2);
    chk("xh_flags", flags, 2);
    chk("xh_x", k210_xpos, 1023);

    send_byte(8'hA5, 1'b1, -1);
    send_byte(8'h01, 1'b1, -1);
    idle(TMO + 200);
    chk("tmo_ferr", ferrs, 3);
    chk("tmo_cnt", err_cnt, 3);
    send_frame(56'hA5_01_40_00_F0_31_5A);
    idle(10);
    chk("tmo_flags", flags, 3);
    chk("tmo_x", k210_xpos, 320);
    chk("tmo_ferr2", ferrs, 3);

    bv0 = bv_cnt;
    @(negedge clk);
    rx = 1'b0;
    idle(1);
    @(negedge clk);
    rx = 1'b1;
    idle(100);
    chk("glitch_bv", bv_cnt, bv0);
    chk("glitch_ferr", ferrs, 3);

    send_byte(8'hA5, 1'b1, -1);
    send_byte(8'h01, 1'b1, -1);
    send_byte(8'h40, 1'b0, -1);
    @(negedge clk);
    rx = 1'b1;
    idle(20);
    chk("fe_ferr", ferrs, 4);
    chk("fe_cnt", err_cnt, 4);
    chk("fe_flags", flags, 3);
    send_frame(56'hA5_03_FF_01_DF_E2_5A);
    idle(10);
    chk("fe_f_flags", flags, 4);
    chk("fe_f_x", k210_xpos, 1023);
    chk("fe_f_y", k210_ypos, 479);
    chk("fe_f_ferr", ferrs, 4);

    send_byte(8'hA5, 1'b1, -1);
    send_byte(8'h01, 1'b1, -1);
    send_byte(8'h40, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'hF0, 1'b1, 74);
    chk("mr_x", k210_xpos, 0);
    chk("mr_y", k210_ypos, 0);
    chk("mr_cnt", err_cnt, 0);
    chk("mr_ferr_o", frame_err, 0);
    send_byte(8'h31, 1'b1, -1);
    send_byte(8'h5A, 1'b1, -1);
    idle(10);
    chk("mr_flags", flags, 4);
    chk("mr_ferr", ferrs, 4);
    send_frame(56'hA5_01_40_00_F0_31_5A);
    idle(10);
    chk("mr_f_flags", flags, 5);
    chk("mr_f_x", k210_xpos, 320);
    chk("mr_f_y", k210_ypos, 240);
    chk("mr_f_cnt", err_cnt, 0);

    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5, 1'b1, -1);
      send_byte(8'h04, 1'b1, -1);
    end
    idle(10);
    chk("sat_cnt", err_cnt, 255);
    chk("sat_ferr", ferrs, 304);
    chk("sat_flags", flags, 5);
    chk("one_cycle_flag", dbl, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
